// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit with its own adder.
// Retires UNROLL multiplier/quotient bits per COMP cycle over a WIDTH-bit datapath.
module ibex_multdiv_iter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned STEPS = WIDTH / UNROLL;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam int unsigned DW    = 2 * WIDTH;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] COMP = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Reject unsupported geometries at elaboration
    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
            $error("ibex_multdiv_iter: UNROLL must be 1, 2, 4 or 8");
        end
        if (WIDTH < 8 || (WIDTH % UNROLL) != 0) begin : g_bad_width
            $error("ibex_multdiv_iter: WIDTH must be >= 8 and a multiple of UNROLL");
        end
    endgenerate

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             dit_q, dit_d;
    logic             neg_q, neg_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operation decode
    logic is_div_c, is_rem_c, signed_a_c, signed_b_c;
    assign is_div_c   = op_q[2];
    assign is_rem_c   = op_q[2] & op_q[1];
    assign signed_a_c = !(op_q == OP_MULHU || op_q == OP_DIVU || op_q == OP_REMU);
    assign signed_b_c = signed_a_c && (op_q != OP_MULHSU);

    // Operand magnitudes; raw a lives in acc_q low half and raw b in mplier_q until PREP
    logic             sign_a_c, sign_b_c, b_zero_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    always_comb begin
        sign_a_c = signed_a_c & acc_q[WIDTH-1];
        sign_b_c = signed_b_c & mplier_q[WIDTH-1];
        b_zero_c = (mplier_q == '0);
        abs_a_c  = sign_a_c ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        abs_b_c  = sign_b_c ? (WIDTH'(0) - mplier_q) : mplier_q;
    end

    // UNROLL chained shift-add steps of the multiplier
    logic [DW-1:0]    mul_acc_c, mul_mcand_c;
    logic [WIDTH-1:0] mul_mplier_c;
    always_comb begin
        mul_acc_c    = acc_q;
        mul_mcand_c  = mcand_q;
        mul_mplier_c = mplier_q;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (mul_mplier_c[0]) begin
                mul_acc_c = mul_acc_c + mul_mcand_c;
            end
            mul_mcand_c  = mul_mcand_c << 1;
            mul_mplier_c = mul_mplier_c >> 1;
        end
    end

    // UNROLL chained restoring-division steps; acc holds {remainder, dividend/quotient}
    logic [WIDTH-1:0] div_rem_c, div_quo_c;
    logic [WIDTH:0]   div_part_c;
    always_comb begin
        div_rem_c  = acc_q[DW-1:WIDTH];
        div_quo_c  = acc_q[WIDTH-1:0];
        div_part_c = '0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            div_part_c = {div_rem_c, div_quo_c[WIDTH-1]};
            if (div_part_c >= {1'b0, mcand_q[WIDTH-1:0]}) begin
                div_rem_c = WIDTH'(div_part_c - {1'b0, mcand_q[WIDTH-1:0]});
                div_quo_c = {div_quo_c[WIDTH-2:0], 1'b1};
            end else begin
                div_rem_c = div_part_c[WIDTH-1:0];
                div_quo_c = {div_quo_c[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and result selection
    logic [DW-1:0]    fix_prod_c;
    logic [WIDTH-1:0] fix_div_c, fix_val_c;
    always_comb begin
        fix_prod_c = neg_q ? (DW'(0) - acc_q) : acc_q;
        fix_div_c  = is_rem_c ? acc_q[DW-1:WIDTH] : acc_q[WIDTH-1:0];
        if (neg_q) begin
            fix_div_c = WIDTH'(0) - fix_div_c;
        end
        if (is_div_c) begin
            fix_val_c = fix_div_c;
        end else if (op_q == OP_MUL) begin
            fix_val_c = fix_prod_c[WIDTH-1:0];
        end else begin
            fix_val_c = fix_prod_c[DW-1:WIDTH];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dit_d    = dit_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && !kill_i) begin
                    op_d     = op_i;
                    dit_d    = data_ind_timing_i;
                    acc_d    = DW'(op_a_i);
                    mplier_d = op_b_i;
                    state_d  = PREP;
                end
            end
            PREP: begin
                count_d = CNT_W'(STEPS);
                if (is_div_c) begin
                    neg_d   = is_rem_c ? sign_a_c : ((sign_a_c ^ sign_b_c) & ~b_zero_c);
                    acc_d   = DW'(abs_a_c);
                    mcand_d = DW'(abs_b_c);
                    if (b_zero_c && !dit_q) begin
                        result_d = is_rem_c ? acc_q[WIDTH-1:0] : '1;
                        state_d  = DONE;
                    end else begin
                        state_d = COMP;
                    end
                end else begin
                    neg_d    = sign_a_c ^ sign_b_c;
                    acc_d    = '0;
                    mcand_d  = DW'(abs_a_c);
                    mplier_d = abs_b_c;
                    state_d  = COMP;
                end
            end
            COMP: begin
                count_d = count_q - CNT_W'(1);
                if (is_div_c) begin
                    acc_d = {div_rem_c, div_quo_c};
                    if (count_d == '0) begin
                        state_d = FIX;
                    end
                end else begin
                    acc_d    = mul_acc_c;
                    mcand_d  = mul_mcand_c;
                    mplier_d = mul_mplier_c;
                    if (count_d == '0 || (!dit_q && mul_mplier_c == '0)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                result_d = fix_val_c;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill_i && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dit_q    <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dit_q    <= dit_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE) & ~kill_i;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench: directed 32x1 vectors, control corner cases and random 16x4 ops.
module tb_ibex_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v32, v16, kill32, ordy, dit;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        rdy32, rdy16, ov32, ov16, busy32, busy16;
    logic [31:0] res32;
    logic [15:0] res16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ibex_multdiv_iter #(.WIDTH(32), .UNROLL(1)) dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v32), .in_ready_o(rdy32), .op_i(op),
        .op_a_i(a), .op_b_i(b), .data_ind_timing_i(dit), .kill_i(kill32),
        .out_valid_o(ov32), .out_ready_i(ordy), .result_o(res32), .busy_o(busy32)
    );

    ibex_multdiv_iter #(.WIDTH(16), .UNROLL(4)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v16), .in_ready_o(rdy16), .op_i(op),
        .op_a_i(a[15:0]), .op_b_i(b[15:0]), .data_ind_timing_i(dit), .kill_i(1'b0),
        .out_valid_o(ov16), .out_ready_i(ordy), .result_o(res16), .busy_o(busy16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics in w bits, from plain signed/unsigned arithmetic
    function automatic logic [31:0] ref_res(input int w, input logic [2:0] o,
                                            input logic [31:0] x, input logic [31:0] y);
        longint mask, ua, ub, sa, sb, r, min_s;
        longint unsigned pa, pb, pu;
        mask  = (longint'(1) << w) - 1;
        min_s = -(longint'(1) << (w - 1));
        ua = longint'(x) & mask;
        ub = longint'(y) & mask;
        sa = ((ua >> (w - 1)) != 0) ? ua - (mask + 1) : ua;
        sb = ((ub >> (w - 1)) != 0) ? ub - (mask + 1) : ub;
        pa = ua;
        pb = ub;
        r  = 0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: begin pu = pa * pb; r = longint'(pu >> w); end
            3'd4: begin
                if (sb == 0) r = -1;
                else if (sa == min_s && sb == -1) r = sa;
                else r = sa / sb;
            end
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: begin
                if (sb == 0) r = sa;
                else if (sa == min_s && sb == -1) r = 0;
                else r = sa % sb;
            end
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    // Edges from accept to out_valid: N+2, div-by-zero shortcut 1, mul early exit k+2
    function automatic int ref_lat(input int w, input int u, input logic [2:0] o,
                                   input logic [31:0] y, input bit d);
        longint mask, ub, mag;
        int n, bl, k;
        n    = w / u;
        mask = (longint'(1) << w) - 1;
        ub   = longint'(y) & mask;
        if (o[2]) return (!d && ub == 0) ? 1 : n + 2;
        if (d) return n + 2;
        mag = ub;
        if ((o == 3'd0 || o == 3'd1) && ((ub >> (w - 1)) != 0)) mag = (mask + 1) - ub;
        bl = 0;
        for (int i = 0; i < w; i++) if ((mag >> i) != 0) bl = i + 1;
        k = (bl + u - 1) / u;
        if (k < 1) k = 1;
        return k + 2;
    endfunction

    // Issue one op, measure accept-to-valid edges, then consume the result
    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit d,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; dit = d;
        if (sel) v16 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0; v32 = 1'b0;
        lat = 0;
        while (!(sel ? ov16 : ov32) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = sel ? {16'h0, res16} : res32;
        if (lat >= 200) begin
            n_vec++; n_err++;
            $display("FAIL timeout: op %0d got no out_valid within 200 edges", o);
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        end else begin
            ordy = 1'b1;
            @(posedge clk); #1;
            ordy = 1'b0;
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] got;
        int          lat;
        bit          seen;

        tbl[0]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 34};
        tbl[1]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 34};
        tbl[2]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 34};
        tbl[3]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 34};
        tbl[4]  = '{3'd5, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 1};
        tbl[5]  = '{3'd7, 32'd5,        32'd0,        1'b0, 32'd5,        1};
        tbl[6]  = '{3'd5, 32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 34};
        tbl[7]  = '{3'd7, 32'd5,        32'd0,        1'b1, 32'd5,        34};
        tbl[8]  = '{3'd0, 32'd3,        32'd5,        1'b0, 32'd15,       5};
        tbl[9]  = '{3'd0, 32'd3,        32'd5,        1'b1, 32'd15,       34};
        tbl[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 3};
        tbl[11] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 34};
        tbl[12] = '{3'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 4};
        tbl[13] = '{3'd0, 32'd7,        32'd0,        1'b0, 32'd0,        3};
        tbl[14] = '{3'd4, 32'h80000000, 32'd0,        1'b0, 32'hFFFFFFFF, 1};
        tbl[15] = '{3'd6, 32'h80000000, 32'd0,        1'b0, 32'h80000000, 1};
        tbl[16] = '{3'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 34};
        tbl[17] = '{3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000001, 34};

        rst = 1'b1; v32 = 1'b0; v16 = 1'b0; kill32 = 1'b0; ordy = 1'b0;
        op = '0; a = '0; b = '0; dit = 1'b0;

        // Reset values, during and just after reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", res32, 32'h0);
        check("rst_valid", 32'(ov32), 32'd0);
        check("rst_busy", 32'(busy32), 32'd0);
        check("rst_ready", 32'(rdy32), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(ov32), 32'd0);
        check("post_rst_ready", 32'(rdy32), 32'd1);
        check("post_rst_result16", {16'h0, res16}, 32'h0);

        // Directed table on the 32x1 instance
        for (int i = 0; i < 18; i++) begin
            run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dit, got, lat);
            check($sformatf("tbl%0d_res", i), got, tbl[i].exp);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Output held while consumer stalls for 10 cycles
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd5; dit = 1'b0; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid_rise", 32'(ov32), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", i), 32'(ov32), 32'd1);
            check($sformatf("hold%0d_res", i), res32, 32'd15);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check("hold_release_busy", 32'(busy32), 32'd0);
        check("hold_release_ready", 32'(rdy32), 32'd1);

        // Kill in COMP cycle 5 drops the operation
        @(negedge clk);
        op = 3'd4; a = 32'd100; b = 32'd7; dit = 1'b0; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        kill32 = 1'b1;
        #1;
        check("kill_busy_before", 32'(busy32), 32'd1);
        @(posedge clk); #1;
        kill32 = 1'b0;
        check("kill_busy", 32'(busy32), 32'd0);
        check("kill_valid", 32'(ov32), 32'd0);
        // Kill while idle blocks acceptance
        @(negedge clk);
        kill32 = 1'b1; v32 = 1'b1;
        #1;
        check("kill_idle_ready", 32'(rdy32), 32'd0);
        @(posedge clk); #1;
        v32 = 1'b0; kill32 = 1'b0;
        check("kill_idle_noaccept", 32'(busy32), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
        end
        check("kill_no_output", 32'(seen), 32'd0);
        run_op(1'b0, 3'd4, 32'd100, 32'd7, 1'b0, got, lat);
        check("after_kill_res", got, 32'd14);
        check("after_kill_lat", 32'(lat), 32'd34);

        // Reset mid-COMP
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd3; dit = 1'b1; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy32), 32'd0);
        check("midrst_valid", 32'(ov32), 32'd0);
        check("midrst_result", res32, 32'h0);
        check("midrst_ready", 32'(rdy32), 32'd1);
        @(negedge clk) rst = 1'b0;
        run_op(1'b0, 3'd5, 32'd1000, 32'd3, 1'b1, got, lat);
        check("after_rst_res", got, 32'd333);
        check("after_rst_lat", 32'(lat), 32'd34);

        // Randomised ops on the 16x4 instance against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  ro;
            logic [15:0] ra, rb;
            bit          rd;
            ro = 3'($urandom_range(0, 7));
            ra = rnd16();
            rb = rnd16();
            rd = 1'($urandom_range(0, 1));
            run_op(1'b1, ro, {16'h0, ra}, {16'h0, rb}, rd, got, lat);
            check($sformatf("rnd%0d_res op%0d a=%h b=%h dit=%0d", i, ro, ra, rb, rd),
                  got, ref_res(16, ro, {16'h0, ra}, {16'h0, rb}));
            check($sformatf("rnd%0d_lat op%0d a=%h b=%h dit=%0d", i, ro, ra, rb, rd),
                  32'(lat), 32'(ref_lat(16, 4, ro, {16'h0, rb}, rd)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
